// File: rtl/seq_cla_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one 4-bit borrow-lookahead slice per clock, LSB first.
// Optional signed-overflow flag is enabled by defining SEQ_SUB_OVERFLOW_EN; otherwise ovf is tied to 0.
module seq_cla_subtractor #(
    parameter  int WIDTH  = 16,
    localparam int NSLICE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("seq_cla_subtractor: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             brw_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;

    // Operands viewed as an array of 4-bit slices so the counter can pick one directly.
    logic [3:0] a_sl [NSLICE];
    logic [3:0] b_sl [NSLICE];

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice_map
            assign a_sl[gi] = a_reg[4*gi +: 4];
            assign b_sl[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    logic [3:0] sa, sb, g, p, d;
    logic [4:0] br;
    logic       last_slice;

    assign sa         = a_sl[cnt_reg];
    assign sb         = b_sl[cnt_reg];
    assign br[0]      = brw_reg;
    assign last_slice = (cnt_reg == CW'(NSLICE - 1));

    // Borrow generate when a=0,b=1; borrow propagates when the bits are equal.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign g[gi]    = ~sa[gi] & sb[gi];
            assign p[gi]    = ~(sa[gi] ^ sb[gi]);
            assign br[gi+1] = g[gi] | (p[gi] & br[gi]);
            assign d[gi]    = sa[gi] ^ sb[gi] ^ br[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            brw_reg  <= 1'b0;
            diff_reg <= '0;
            bout_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            if (start) begin
                a_reg   <= a;
                b_reg   <= b;
                brw_reg <= bin;
                cnt_reg <= '0;
            end
        end else if (state_reg == RUN) begin
            for (int i = 0; i < NSLICE; i++) begin
                if (cnt_reg == CW'(i)) begin
                    diff_reg[4*i +: 4] <= d;
                end
            end
            brw_reg <= br[4];
            cnt_reg <= cnt_reg + 1'b1;
            if (last_slice) begin
                bout_reg <= br[4];
            end
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;

`ifdef SEQ_SUB_OVERFLOW_EN
    logic ovf_reg;

    // Overflow on the MSB slice: operand signs differ and the result sign differs from the minuend.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_slice) begin
            ovf_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (d[3] != a_reg[WIDTH-1]);
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// Scoreboard bench for seq_cla_subtractor (WIDTH=16): expected results queued at start, checked at done.
module tb_seq_cla_subtractor;
    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done, bout, ovf;
    logic [W-1:0] diff;

    seq_cla_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   checks    = 0;
    int   failures  = 0;
    int   done_cnt  = 0;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t       e;
        logic [W:0] r;
        r      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        e.diff = r[W-1:0];
        e.bout = r[W];
`ifdef SEQ_SUB_OVERFLOW_EN
        e.ovf  = (ma[W-1] != mb[W-1]) && (e.diff[W-1] != ma[W-1]);
`else
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    // Runs one operation; inject>0 pulses a second start (a=0xFFFF) in that RUN cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                          input int inject, input string tag);
        int   busy_n;
        bit   seen;
        exp_t e;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        sb_q.push_back(model(ta, tb, tbin));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        busy_n = 0;
        seen   = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (done === 1'b1) begin
                check_val({tag, "_lat"}, 32'(n), 32'(NS + 1));
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_n++;
            start = (n == inject);
            if (n == inject) a = 16'hFFFF;
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) begin
            check_val({tag, "_timeout"}, 32'(0), 32'(1));
            void'(sb_q.pop_front());
        end else begin
            check_val({tag, "_busy_cycles"}, 32'(busy_n), 32'(NS));
            e = sb_q.pop_front();
            last_exp = e;
            check_val({tag, "_diff"}, 32'(diff), 32'(e.diff));
            check_val({tag, "_bout"}, 32'(bout), 32'(e.bout));
            check_val({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
        end
        $display("op %s a=0x%04h b=0x%04h bin=%0d diff=0x%04h bout=%0d ovf=%0d",
                 tag, ta, tb, tbin, diff, bout, ovf);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_done", 32'(done), 32'(0));
        check_val("rst_diff", 32'(diff), 32'(0));
        check_val("rst_bout", 32'(bout), 32'(0));
        check_val("rst_ovf",  32'(ovf),  32'(0));

        run_op(16'h1234, 16'h0234, 1'b0, 0, "basic");
        run_op(16'h0000, 16'h0001, 1'b0, 0, "ripple");
        run_op(16'h0005, 16'h0003, 1'b1, 0, "bin1");
        run_op(16'h0003, 16'h0003, 1'b1, 0, "bin_wrap");
        run_op(16'h8000, 16'h0001, 1'b0, 0, "ovf_neg");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, "ovf_pos");
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, "ovf_pos2");

        // A start during the DONE cycle must be ignored and leave the result intact.
        start = 1'b1; a = 16'h1111; b = 16'h2222; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_val("done_start_busy", 32'(busy), 32'(0));
        check_val("done_start_diff", 32'(diff), 32'(last_exp.diff));
        @(negedge clk);
        check_val("done_start_idle", 32'(busy), 32'(0));

        d0 = done_cnt;
        run_op(16'h00FF, 16'h000F, 1'b0, 2, "ignore");
        repeat (6) @(negedge clk);
        check_val("ignore_done_count", 32'(done_cnt - d0), 32'(1));

        // Abort with reset in the third RUN cycle.
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_busy", 32'(busy), 32'(0));
        check_val("abort_done", 32'(done), 32'(0));
        check_val("abort_diff", 32'(diff), 32'(0));
        check_val("abort_bout", 32'(bout), 32'(0));
        check_val("abort_ovf",  32'(ovf),  32'(0));
        d0 = done_cnt;
        repeat (8) @(negedge clk);
        check_val("abort_no_done", 32'(done_cnt), 32'(d0));
        run_op(16'h0010, 16'h0001, 1'b0, 0, "post_rst");

        for (int i = 0; i < 8; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0, "rand");
        end

        check_val("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end
endmodule
